// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// Carries out_popcnt only when LOGIC_UNIT_POPCOUNT_EN is defined.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 3
);
`ifdef LOGIC_UNIT_POPCOUNT_EN
    localparam int CNT_W = $clog2(WIDTH + 1);
`endif

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_ones;
`ifdef LOGIC_UNIT_POPCOUNT_EN
    logic [CNT_W-1:0] out_popcnt;
`endif

`ifdef LOGIC_UNIT_POPCOUNT_EN
    modport slave (
        input  in_valid, in_op, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_ones,
        output out_popcnt
    );
    modport master (
        output in_valid, in_op, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_ones,
        input  out_popcnt
    );
`else
    modport slave (
        input  in_valid, in_op, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_ones
    );
    modport master (
        output in_valid, in_op, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_ones
    );
`endif
endinterface

// File: rtl/logic_unit_pipe.sv
// One-stage valid/ready bitwise logic unit with OR-accumulate stream mode.
// Optional registered ones-count output enabled by LOGIC_UNIT_POPCOUNT_EN.
module logic_unit_pipe #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 3
) (
    input logic            clk,
    input logic            reset,
    logic_unit_pipe_if.slave bus
);
    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_NOR   = 3'd3,
        OP_NAND  = 3'd4,
        OP_XNOR  = 3'd5,
        OP_ORACC = 3'd6,
        OP_PASSA = 3'd7
    } op_e;

    if (OP_W != 3) begin : g_bad_op_w
        $error("logic_unit_pipe: OP_W must be 3");
    end

    logic             accept;
    logic             vld_q;
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] acc_q;

    assign op = op_e'(bus.in_op);
    assign a  = bus.in_a;
    assign b  = bus.in_b;

    // A new beat fits whenever the output slot is empty or drains now.
    assign bus.in_ready = !vld_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // Result of the beat currently presented at the input.
    always_comb begin
        res_d = '0;
        unique case (op)
            OP_AND:   res_d = a & b;
            OP_OR:    res_d = a | b;
            OP_XOR:   res_d = a ^ b;
            OP_NOR:   res_d = ~(a | b);
            OP_NAND:  res_d = ~(a & b);
            OP_XNOR:  res_d = ~(a ^ b);
            OP_ORACC: res_d = acc_q | a | b;
            OP_PASSA: res_d = a;
            default:  res_d = '0;
        endcase
    end

    // Accumulator only moves on accepted ORACC beats; last beat closes the stream.
    always_comb begin
        acc_d = acc_q;
        if (accept && op == OP_ORACC) begin
            if (bus.in_last) begin
                acc_d = '0;
            end else begin
                acc_d = res_d;
            end
        end
    end

    // Output slot and accumulator state; reset beats any same-cycle accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= 1'b0;
            res_q <= '0;
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
            if (accept) begin
                vld_q <= 1'b1;
                res_q <= res_d;
            end else if (bus.out_ready) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid  = vld_q;
    assign bus.out_result = res_q;
    assign bus.out_zero   = (res_q == '0);
    assign bus.out_ones   = (res_q == '1);

`ifdef LOGIC_UNIT_POPCOUNT_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    logic [CNT_W-1:0] cnt_q;

    // Ones count captured at the same edge as the result it describes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= popcount(res_d);
        end
    end

    assign bus.out_popcnt = cnt_q;
`endif
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomised plus directed bench for logic_unit_pipe against a behavioural model.
// Also exercises a WIDTH=1 instance.
module tb_logic_unit_pipe;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(W), .OP_W(3)) bus ();
    logic_unit_pipe_if #(.WIDTH(1), .OP_W(3)) bus1 ();

    logic_unit_pipe #(.WIDTH(W), .OP_W(3)) u_dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    logic_unit_pipe #(.WIDTH(1), .OP_W(3)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    int total = 0;
    int bad   = 0;

    logic         m_val;
    logic [W-1:0] m_res;
    logic [W-1:0] m_acc;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input int op, input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [W-1:0] acc);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            3: return ~(a | b);
            4: return ~(a & b);
            5: return ~(a ^ b);
            6: return acc | a | b;
            default: return a;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic last, input logic ordy);
        bus.in_valid  = v;
        bus.in_op     = op;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_last   = last;
        bus.out_ready = ordy;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step(input string tag);
        logic         acc_now;
        logic [W-1:0] r;
        #1;
        chk({tag, ".rdy"}, 64'(bus.in_ready), 64'(!m_val || bus.out_ready));
        acc_now = bus.in_valid && (!m_val || bus.out_ready);
        r = ref_op(int'(bus.in_op), bus.in_a, bus.in_b, m_acc);
        @(posedge clk);
        #1;
        if (reset) begin
            m_val = 1'b0;
            m_res = '0;
            m_acc = '0;
        end else if (acc_now) begin
            m_val = 1'b1;
            m_res = r;
            if (bus.in_op == 3'd6) m_acc = bus.in_last ? '0 : r;
        end else if (bus.out_ready) begin
            m_val = 1'b0;
        end
        chk({tag, ".vld"}, 64'(bus.out_valid), 64'(m_val));
        if (m_val || reset) begin
            chk({tag, ".res"}, 64'(bus.out_result), 64'(m_res));
            chk({tag, ".zero"}, 64'(bus.out_zero), 64'(m_res == 0));
            chk({tag, ".ones"}, 64'(bus.out_ones), 64'(m_res == {W{1'b1}}));
`ifdef LOGIC_UNIT_POPCOUNT_EN
            chk({tag, ".pop"}, 64'(bus.out_popcnt), 64'($countones(m_res)));
`endif
        end
        @(negedge clk);
    endtask

    logic [W-1:0] exp2 [8];
    logic [W-1:0] exp3 [4];
    logic [W-1:0] a3 [4];
    logic [W-1:0] b3 [4];
    logic         l3 [4];
    logic         acc1;
    logic [W-1:0] r1;

    initial begin
        m_val = 1'b0;
        m_res = '0;
        m_acc = '0;
        bus1.in_valid  = 1'b0;
        bus1.in_op     = '0;
        bus1.in_a      = '0;
        bus1.in_b      = '0;
        bus1.in_last   = 1'b0;
        bus1.out_ready = 1'b1;
        reset = 1'b1;
        drive(1'b1, 3'd1, 32'h1234_5678, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        step("rst0");
        step("rst1");
        chk("rst.rdy", 64'(bus.in_ready), 64'd1);
        chk("rst.vld", 64'(bus.out_valid), 64'd0);
        reset = 1'b0;

        drive(1'b1, 3'd1, 32'hF0F0_0000, 32'h0000_0F0F, 1'b0, 1'b1);
        step("t1");
        chk("t1.lit", 64'(bus.out_result), 64'h0000_0000_F0F0_0F0F);

        exp2 = '{32'h0000_00FF, 32'h00FF_FFFF, 32'h00FF_FF00, 32'hFF00_0000,
                 32'hFFFF_FF00, 32'hFF00_00FF, 32'h00FF_FFFF, 32'h0000_FFFF};
        for (int op = 0; op < 8; op++) begin
            drive(1'b1, 3'(op), 32'h0000_FFFF, 32'h00FF_00FF, 1'b1, 1'b1);
            step("t2");
            chk($sformatf("t2.op%0d", op), 64'(bus.out_result), 64'(exp2[op]));
        end

        a3 = '{32'd1, 32'd2, 32'd0, 32'd4};
        b3 = '{32'd0, 32'd0, 32'd8, 32'd0};
        l3 = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp3 = '{32'd1, 32'd3, 32'd11, 32'd4};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd6, a3[i], b3[i], l3[i], 1'b1);
            step("t3");
            chk($sformatf("t3.b%0d", i), 64'(bus.out_result), 64'(exp3[i]));
        end

        drive(1'b1, 3'd1, 32'hAAAA_0000, 32'h0000_5555, 1'b0, 1'b1);
        step("t4a");
        drive(1'b1, 3'd0, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("t4h");
            chk("t4.hold", 64'(bus.out_result), 64'h0000_0000_AAAA_5555);
        end
        bus.out_ready = 1'b1;
        step("t4r");
        chk("t4.beat2", 64'(bus.out_result), 64'h0000_0000_0F0F_0000);
        drive(1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
        step("t4d");
        chk("t4.once", 64'(bus.out_valid), 64'd0);

        drive(1'b1, 3'd6, 32'd1, 32'd0, 1'b0, 1'b1);
        step("t5a");
        drive(1'b1, 3'd6, 32'd2, 32'd0, 1'b0, 1'b1);
        step("t5b");
        reset = 1'b1;
        drive(1'b1, 3'd6, 32'd5, 32'd0, 1'b0, 1'b1);
        step("t5r");
        chk("t5.vld", 64'(bus.out_valid), 64'd0);
        reset = 1'b0;
        drive(1'b1, 3'd6, 32'd4, 32'd0, 1'b1, 1'b1);
        step("t5c");
        chk("t5.res", 64'(bus.out_result), 64'd4);

        drive(1'b1, 3'd5, 32'd0, 32'd0, 1'b0, 1'b1);
        step("t6");
        chk("t6.ones", 64'(bus.out_ones), 64'd1);
`ifdef LOGIC_UNIT_POPCOUNT_EN
        chk("t6.pop", 64'(bus.out_popcnt), 64'd32);
`endif

        for (int i = 0; i < 500; i++) begin
            drive(1'(($urandom % 4) != 0), 3'($urandom % 8),
                  ($urandom % 5 == 0) ? 32'h0 : 32'($urandom),
                  ($urandom % 5 == 0) ? 32'hFFFF_FFFF : 32'($urandom),
                  1'(($urandom % 4) == 0), 1'(($urandom % 3) != 0));
            step("rnd");
        end
        drive(1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
        step("drain");

        acc1 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            bus1.in_valid = 1'b1;
            bus1.in_op    = 3'($urandom % 8);
            bus1.in_a     = 1'($urandom);
            bus1.in_b     = 1'($urandom);
            bus1.in_last  = 1'($urandom);
            r1 = ref_op(int'(bus1.in_op), W'(bus1.in_a), W'(bus1.in_b), W'(acc1));
            if (bus1.in_op == 3'd6) acc1 = bus1.in_last ? 1'b0 : r1[0];
            @(posedge clk);
            #1;
            chk("w1.res", 64'(bus1.out_result), 64'(r1[0]));
            chk("w1.excl", 64'(bus1.out_zero ^ bus1.out_ones), 64'd1);
            chk("w1.ones", 64'(bus1.out_ones), 64'(r1[0]));
`ifdef LOGIC_UNIT_POPCOUNT_EN
            chk("w1.pop", 64'(bus1.out_popcnt), 64'(r1[0]));
`endif
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
